// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit that owns the HI/LO registers.
// Ports: clk, reset (sync, active-high), start, md_op[2:0], dataA, dataB; busy, hi, lo.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [31:0]   r_hi, w_hi;
  logic [31:0]   r_lo, w_lo;
  logic [31:0]   r_phi, w_phi;
  logic [31:0]   r_plo, w_plo;
  logic          r_dz, w_dz;

  logic [63:0]   w_smul;
  logic [63:0]   w_umul;
  logic          w_a_neg;
  logic          w_b_neg;
  logic [31:0]   w_abs_a;
  logic [31:0]   w_abs_b;
  logic [31:0]   w_mq;
  logic [31:0]   w_mr;
  logic [31:0]   w_sq;
  logic [31:0]   w_sr;
  logic [31:0]   w_uq;
  logic [31:0]   w_ur;
  logic          w_bz;

  // Low 64 bits of the extended product are the exact 32x32 result.
  assign w_smul = {{32{dataA[31]}}, dataA} * {{32{dataB[31]}}, dataB};
  assign w_umul = {32'd0, dataA} * {32'd0, dataB};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  assign w_bz    = (dataB == 32'd0);
  assign w_a_neg = dataA[31];
  assign w_b_neg = dataB[31];
  assign w_abs_a = w_a_neg ? (32'd0 - dataA) : dataA;
  assign w_abs_b = w_b_neg ? (32'd0 - dataB) : dataB;
  assign w_mq    = w_bz ? 32'd0 : (w_abs_a / w_abs_b);
  assign w_mr    = w_bz ? 32'd0 : (w_abs_a % w_abs_b);
  assign w_sq    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_mq) : w_mq;
  assign w_sr    = w_a_neg ? (32'd0 - w_mr) : w_mr;
  assign w_uq    = w_bz ? 32'd0 : (dataA / dataB);
  assign w_ur    = w_bz ? 32'd0 : (dataA % dataB);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_hi    = r_hi;
    w_lo    = r_lo;
    w_phi   = r_phi;
    w_plo   = r_plo;
    w_dz    = r_dz;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          unique case (md_op)
            3'b000: begin
              {w_phi, w_plo} = w_smul;
              w_dz    = 1'b0;
              w_cnt   = CW'(MULT_CYCLES);
              w_state = S_RUN;
            end
            3'b001: begin
              {w_phi, w_plo} = w_umul;
              w_dz    = 1'b0;
              w_cnt   = CW'(MULT_CYCLES);
              w_state = S_RUN;
            end
            3'b010: begin
              w_phi   = w_sr;
              w_plo   = w_sq;
              w_dz    = w_bz;
              w_cnt   = CW'(DIV_CYCLES);
              w_state = S_RUN;
            end
            3'b011: begin
              w_phi   = w_ur;
              w_plo   = w_uq;
              w_dz    = w_bz;
              w_cnt   = CW'(DIV_CYCLES);
              w_state = S_RUN;
            end
            3'b100: w_hi = dataA;
            3'b101: w_lo = dataA;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (r_cnt > CW'(1)) begin
          w_cnt = r_cnt - CW'(1);
        end else begin
          w_cnt   = '0;
          w_state = S_IDLE;
          // Divide by zero leaves HI/LO untouched.
          if (!r_dz) begin
            w_hi = r_phi;
            w_lo = r_plo;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_phi   <= '0;
      r_plo   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_hi    <= w_hi;
      r_lo    <= w_lo;
      r_phi   <= w_phi;
      r_plo   <= w_plo;
      r_dz    <= w_dz;
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Drives vectors after each rising edge and checks busy/hi/lo against hand values.
module tb_md_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp;
  int n_bad;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .dataA(dataA),
    .dataB(dataB),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [2:0] op, input logic [31:0] a,
                    input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    dataA = a;
    dataB = b;
    step();
    start = 1'b0;
    md_op = 3'b110;
    dataA = 32'hDEAD_BEEF;
    dataB = 32'h0BAD_F00D;
  endtask

  // Sample busy for n cycles after the start edge, then expect it low.
  task automatic busy_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      step();
    end
    chk({tag, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'b110;
    dataA = 32'd0;
    dataB = 32'd0;
    step();
    step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // reset overrides start
    go(3'b100, 32'h5555_5555, 32'd0);
    chk("rst_ovr_hi", hi, 32'd0);
    chk("rst_ovr_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    go(3'b000, 32'hFFFF_FFFD, 32'd5);
    chk("mult_hold_hi", hi, 32'd0);
    busy_run("mult", 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    go(3'b001, 32'hFFFF_FFFF, 32'd2);
    busy_run("multu", 5);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    go(3'b010, 32'hFFFF_FFF9, 32'd2);
    busy_run("div", 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    go(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_run("divov", 10);
    chk("divov_lo", lo, 32'h8000_0000);
    chk("divov_hi", hi, 32'h0000_0000);

    go(3'b011, 32'd100, 32'd7);
    busy_run("divu", 10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    go(3'b100, 32'h0000_1234, 32'd0);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo", lo, 32'd14);
    go(3'b101, 32'h0000_5678, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_5678);

    go(3'b111, 32'hFFFF_FFFF, 32'd3);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_hi", hi, 32'h0000_1234);

    go(3'b011, 32'd99, 32'd0);
    busy_run("dz", 10);
    chk("dz_hi", hi, 32'h0000_1234);
    chk("dz_lo", lo, 32'h0000_5678);

    // starts while busy are ignored
    go(3'b000, 32'd3, 32'd4);
    chk("sb_busy0", {31'd0, busy}, 32'd1);
    step();
    chk("sb_busy1", {31'd0, busy}, 32'd1);
    go(3'b010, 32'd100, 32'd7);
    chk("sb_busy2", {31'd0, busy}, 32'd1);
    go(3'b101, 32'h0000_AAAA, 32'd0);
    chk("sb_mtlo_lo", lo, 32'h0000_5678);
    busy_run("sb", 2);
    chk("sb_hi", hi, 32'd0);
    chk("sb_lo", lo, 32'd12);

    // back-to-back: start in the first idle cycle
    go(3'b000, 32'd7, 32'd6);
    busy_run("b2b", 5);
    chk("b2b_lo", lo, 32'd42);

    // reset on the 4th busy cycle aborts the divide
    go(3'b011, 32'd100, 32'd7);
    step();
    step();
    step();
    chk("ra_busy4", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ra_busy", {31'd0, busy}, 32'd0);
    chk("ra_hi", hi, 32'd0);
    chk("ra_lo", lo, 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("ra_late_busy", {31'd0, busy}, 32'd0);
    chk("ra_late_hi", hi, 32'd0);
    chk("ra_late_lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the EX stage, beside the ALU.
- Consumes the same forwarded operands (dataA = rs, dataB = rt) and holds the architectural HI/LO registers.
- HI/LO feed the EX result mux for mfhi/mflo.
- Drives busy so the hazard unit can stall md-class instructions until the operation completes.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; operation selected by md_op
- md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 no-op
- dataA  input  32  rs operand (forwarded)
- dataB  input  32  rt operand (forwarded)
- busy  output  1  multiply/divide in progress
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high.
- Reset:
  - At a rising clk edge with reset=1: hi=0, lo=0, busy=0, internal counter=0, pending result cleared.
  - Reset overrides start.
  - Reset during an operation aborts it; HI/LO do not take the pending result.
- States: IDLE (busy=0), RUN (busy=1). State is held in busy plus a down-counter cnt.
- IDLE, start=1, md_op in {000..011}:
  - At that edge, compute the full result from dataA/dataB into internal pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu); set busy=1.
  - Operand changes after the start edge have no effect.
- IDLE, start=1, md_op=100: hi<=dataA at that edge; busy stays 0. md_op=101: lo<=dataA likewise.
- IDLE, start=1, md_op 110/111: no state change.
- RUN:
  - Each edge with cnt>1: cnt<=cnt-1.
  - Edge with cnt==1: hi<=pend_hi, lo<=pend_lo, busy<=0, cnt<=0.
  - busy is therefore high for exactly MULT_CYCLES/DIV_CYCLES cycles after the start edge.
  - New HI/LO are visible in the cycle busy first reads 0.
- start=1 while busy=1 (any md_op, including mthi/mtlo) is ignored. The hazard unit guarantees this never happens; the unit must still not corrupt state.
- HI/LO are registered outputs; they change only at reset, at completion, or on mthi/mtlo.
- Arithmetic:
  - mult: signed 32x32 -> 64-bit product; hi=product[63:32], lo=product[31:0].
  - multu: same, unsigned.
  - div: signed. lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - div overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
  - divu: unsigned quotient in lo, remainder in hi.
  - Divide by zero (dataB=0, div or divu): full DIV_CYCLES busy period still runs; at completion hi and lo keep their pre-start values.
- Back-to-back: a new start is accepted in the first cycle busy=0 after completion. Its operands may read the just-updated hi/lo through forwarding.

Test Plan:
- Signed multiply: reset 2 cycles; start mult, dataA=0xFFFFFFFD (-3), dataB=5 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- Unsigned multiply: multu with dataA=0xFFFFFFFF, dataB=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- Signed divide:
  - div with dataA=0xFFFFFFF9 (-7), dataB=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - div with 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: mthi 0x1234 then mtlo 0x5678 (busy stays 0; hi/lo update next edge); divu with dataB=0 -> busy 10 cycles; afterwards hi=0x1234, lo=0x5678.
- Start during busy: start mult 3*4, and 2 cycles later pulse start with div 100/7 and with mtlo 0xAAAA -> both ignored; completion gives hi=0, lo=12, busy low after 5 cycles total.
- Reset mid-operation: start divu 100/7, assert reset on the 4th busy cycle -> next edge busy=0, hi=0, lo=0; no later update to hi=2/lo=14.
